// File: rtl/dds_sin_rom.sv
// -----------------------------------------------------------------------------
// dds_sin_rom
//   Sine look-up memory for the DDS slave core. One full sine period is held
//   as 1024 samples of 16 bits, in offset binary (0x8000 = zero crossing).
//   Only a 257-entry quarter-wave table is stored. Quadrant symmetry rebuilds
//   the other three quarters.
//
//   Pipeline (latency 2, one new address per clock):
//     stage 1 : registers the quarter-table index and the negate flag
//     stage 2 : registers the table sample, mirrored or negated, into q
//
// Ports
//   clock   in   1   system clock, rising-edge active
//   reset   in   1   synchronous, active-low reset
//   address in  10   sample index a, phase = 2*pi*a/1024
//   q       out 16   sine sample, offset binary
// -----------------------------------------------------------------------------
module dds_sin_rom (
  input  logic        clock,
  input  logic        reset,
  input  logic [9:0]  address,
  output logic [15:0] q
);

  typedef logic [256:0][15:0] lut_t;

  // Quarter table L[k] = 32768 + round(32767*sin(pi*k/512)), k = 0..256.
  // A Taylor series keeps the elaboration-time evaluation free of math
  // library calls. Every argument lies in [0, pi/2], where 11 terms are far
  // below one LSB of error. The sine is non-negative here, so floor(v+0.5)
  // is round-half-away-from-zero.
  function automatic lut_t build_quarter_table();
    lut_t t;
    real  x;
    real  term;
    real  sum;
    real  v;
    t = '0;
    for (int k = 0; k <= 256; k++) begin
      x    = 3.14159265358979323846 * real'(k) / 512.0;
      sum  = x;
      term = x;
      for (int n = 1; n < 12; n++) begin
        term = -term * x * x / (real'(2 * n) * real'(2 * n + 1));
        sum  = sum + term;
      end
      v    = 32767.0 * sum;
      t[k] = 16'(32768 + $rtoi(v + 0.5));
    end
    return t;
  endfunction

  localparam lut_t QUARTER_LUT = build_quarter_table();

  logic [8:0]  idx_s;
  logic [8:0]  idx_r;
  logic        neg_r;
  logic [15:0] lut_s;
  logic [15:0] result_s;

  // Quadrant decode: odd quadrants read the quarter table mirrored (256-k).
  always_comb begin
    idx_s = {1'b0, address[7:0]};
    if (address[8]) begin
      idx_s = 9'd256 - {1'b0, address[7:0]};
    end else begin
      idx_s = {1'b0, address[7:0]};
    end
  end

  // Stage 1: table index and negate flag (second half of the period).
  always_ff @(posedge clock) begin
    if (!reset) begin
      idx_r <= 9'd0;
      neg_r <= 1'b0;
    end else begin
      idx_r <= idx_s;
      neg_r <= address[9];
    end
  end

  // Negation about mid-scale. 65536 - L taken modulo 2^16 is the two's
  // complement of L. L is never 0, so the result stays in 1..65535.
  always_comb begin
    lut_s    = QUARTER_LUT[idx_r];
    result_s = lut_s;
    if (neg_r) begin
      result_s = (~lut_s) + 16'd1;
    end else begin
      result_s = lut_s;
    end
  end

  // Stage 2: registered output. Reset parks the DAC at mid-scale.
  always_ff @(posedge clock) begin
    if (!reset) begin
      q <= 16'h8000;
    end else begin
      q <= result_s;
    end
  end

endmodule

// File: tb/tb_dds_sin_rom.sv
// -----------------------------------------------------------------------------
// tb_dds_sin_rom
//   Scoreboard bench for dds_sin_rom. The driver applies (reset, address) once
//   per clock. After each rising edge it pushes the q that the transfer
//   function predicts for that edge. A monitor on the falling edge pops the
//   queue and compares the prediction with q.
// -----------------------------------------------------------------------------
module tb_dds_sin_rom;

  logic        clock;
  logic        reset;
  logic [9:0]  address;
  logic [15:0] q;

  dds_sin_rom dut (
    .clock   (clock),
    .reset   (reset),
    .address (address),
    .q       (q)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int    exp;
    int    addr;   // address the sample belongs to, -1 for reset/mid-scale
    string name;
  } item_t;

  item_t       sb[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  string       cur_name = "init";
  logic        prev_rst = 1'b0;
  int          prev_addr = 0;
  logic        record   = 1'b0;
  int          obs [0:1023];
  bit          seen [0:1023];

  // Transfer function, computed straight from the sine definition.
  function automatic int model_q(input int a);
    real v;
    int  r;
    v = 32767.0 * $sin(2.0 * 3.14159265358979323846 * real'(a) / 1024.0);
    if (v >= 0.0) r = $rtoi($floor(v + 0.5));
    else          r = -$rtoi($floor(-v + 0.5));
    return 32768 + r;
  endfunction

  // Predicted q after an edge. A low reset at this edge or at the edge
  // before forces mid-scale. Otherwise q is the sample addressed one edge
  // earlier, i.e. two edges after that address was presented.
  task automatic step(input logic rst, input int addr);
    item_t it;
    reset   = rst;
    address = 10'(addr);
    @(posedge clock);
    it.name = cur_name;
    if (!rst || !prev_rst) begin
      it.exp  = 32'h8000;
      it.addr = -1;
    end else begin
      it.exp  = model_q(prev_addr);
      it.addr = prev_addr;
    end
    sb.push_back(it);
    prev_rst  = rst;
    prev_addr = addr;
    #1;
  endtask

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  // Monitor: one output sample per clock, compared against the scoreboard.
  always @(negedge clock) begin
    item_t it;
    if (sb.size() > 0) begin
      it = sb.pop_front();
      check(it.name, int'(q), it.exp);
      if (record && it.addr >= 0) begin
        obs[it.addr]  = int'(q);
        seen[it.addr] = 1'b1;
      end
    end
  end

  initial begin
    int a;
    reset   = 1'b0;
    address = 10'd0;
    for (int i = 0; i < 1024; i++) begin
      obs[i]  = 0;
      seen[i] = 1'b0;
    end

    // Reset with a held address, then release.
    cur_name = "reset_hold";
    step(1'b0, 300);
    step(1'b0, 300);
    cur_name = "reset_release";
    step(1'b1, 300);
    step(1'b1, 300);
    step(1'b1, 300);

    // Cardinal, 45-degree and near-zero points, back to back.
    cur_name = "cardinal";
    step(1'b1, 0);   step(1'b1, 256); step(1'b1, 512); step(1'b1, 768);
    cur_name = "deg45";
    step(1'b1, 128); step(1'b1, 384); step(1'b1, 640); step(1'b1, 896);
    cur_name = "near_zero";
    step(1'b1, 1);   step(1'b1, 511); step(1'b1, 513); step(1'b1, 1023);
    step(1'b1, 1023);
    step(1'b1, 1023);

    // The literal spot values the transfer function must give.
    check("ref_q0",    model_q(0),    32768);
    check("ref_q256",  model_q(256),  65535);
    check("ref_q768",  model_q(768),  1);
    check("ref_q128",  model_q(128),  55938);
    check("ref_q640",  model_q(640),  9598);
    check("ref_q1",    model_q(1),    32969);
    check("ref_q1023", model_q(1023), 32567);

    // Full sweep 0..1023 with wrap back to 0, recording outputs per address.
    cur_name = "sweep";
    record   = 1'b1;
    for (int i = 0; i < 1024 + 8; i++) step(1'b1, i % 1024);
    step(1'b1, 8);
    step(1'b1, 9);
    record = 1'b0;

    // Reset pulse in the middle of an incrementing sweep.
    cur_name = "reset_mid_sweep";
    for (int i = 100; i < 110; i++) step(1'b1, i);
    step(1'b0, 110);
    for (int i = 111; i < 121; i++) step(1'b1, i);

    // Random addresses with occasional single-edge reset pulses.
    cur_name = "random";
    for (int i = 0; i < 600; i++) begin
      a = int'($urandom_range(1023, 0));
      step(($urandom_range(39, 0) == 0) ? 1'b0 : 1'b1, a);
    end
    step(1'b1, 0);
    step(1'b1, 0);

    // Drain: the monitor pops the last entry on the next falling edge.
    repeat (2) @(negedge clock);
    #1;
    check("scoreboard_drained", sb.size(), 0);

    // Half-period antisymmetry on the recorded sweep.
    for (int i = 0; i < 512; i++) begin
      if (seen[i] && seen[i + 512]) begin
        check("antisymmetry", obs[i] + obs[i + 512], 65536);
      end else begin
        check("sweep_coverage", 0, 1);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
